ex_div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage, covering MIPS DIV and DIVU.
- Takes its operands from the ID/EX pipeline register outputs (value_A, value_B).
- Drives the stall signal back to the upstream pipeline registers, holding the divide in EX until the result is ready.
- Computes quotient and remainder with a radix-2 restoring algorithm, one bit per cycle, and presents them in HILO layout for the HI/LO write path.

---
 rtl/ex_div_unit.sv | 131 +++++++++++++
 tb/tb_ex_div_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// EX-stage multi-cycle divider for MIPS DIV/DIVU: radix-2 restoring, one quotient bit per cycle.
// Holds the pipeline through stall and presents {remainder, quotient} in HILO layout.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rset,
    input  logic               start,
    input  logic               sign,
    input  logic               cancel,
    input  logic [WIDTH-1:0]   value_A,
    input  logic [WIDTH-1:0]   value_B,
    output logic               stall,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] HILO_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   dividend_raw;
    logic               quo_neg;
    logic               rem_neg;
    logic               div_zero;
    logic [2*WIDTH-1:0] hilo_reg;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [2*WIDTH-1:0] final_value;

    assign accept    = (state == IDLE) && start && !cancel;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign abs_a     = (sign && value_A[WIDTH-1]) ? -value_A : value_A;
    assign abs_b     = (sign && value_B[WIDTH-1]) ? -value_B : value_B;

    // One restoring step: a negative trial difference (MSB set) keeps the old remainder.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};

    assign rem_fix     = rem_neg ? -rem : rem;
    assign quo_fix     = quo_neg ? -quo : quo;
    assign final_value = div_zero ? {dividend_raw, {WIDTH{1'b1}}} : {rem_fix, quo_fix};

    // The result is exposed combinationally in DONE so a same-cycle cancel leaves HILO_out untouched.
    assign HILO_out = result_valid ? final_value : hilo_reg;

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        result_valid = 1'b0;
        stall        = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                    stall      = 1'b0;
                end
            end
            CALC: begin
                stall = 1'b0;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (cancel) begin
            state_next   = IDLE;
            result_valid = 1'b0;
            stall        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            count        <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            quo_neg      <= 1'b0;
            rem_neg      <= 1'b0;
            div_zero     <= 1'b0;
            hilo_reg     <= '0;
        end else if (accept) begin
            count        <= '0;
            rem          <= '0;
            quo          <= abs_a;
            divisor      <= abs_b;
            dividend_raw <= value_A;
            quo_neg      <= sign && (value_A[WIDTH-1] ^ value_B[WIDTH-1]);
            rem_neg      <= sign && value_A[WIDTH-1];
            div_zero     <= (value_B == '0);
        end else if (state == CALC && !cancel) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 1'b1;
        end else if (result_valid) begin
            hilo_reg <= final_value;
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: hand-computed DIV/DIVU results, latency/stall timing,
// cancel, asynchronous reset and back-to-back operation.
module tb_ex_div_unit;

    logic        clk;
    logic        rset;
    logic        start;
    logic        sign;
    logic        cancel;
    logic [31:0] value_A;
    logic [31:0] value_B;
    logic        stall;
    logic        result_valid;
    logic [63:0] HILO_out;

    int check_count;
    int error_count;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rset        (rset),
        .start       (start),
        .sign        (sign),
        .cancel      (cancel),
        .value_A     (value_A),
        .value_B     (value_B),
        .stall       (stall),
        .result_valid(result_valid),
        .HILO_out    (HILO_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Starts a divide right after a rising edge and follows it through to its DONE cycle.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] expected);
        int bad_cycles;
        bad_cycles = 0;
        start   = 1'b1;
        sign    = sgn;
        value_A = a;
        value_B = b;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (stall !== 1'b0 || result_valid !== 1'b0) bad_cycles++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput({tag, "_busy_cycles"}, 64'(bad_cycles), 64'd0);
        checkOutput({tag, "_valid"}, {63'd0, result_valid}, 64'd1);
        checkOutput({tag, "_stall_done"}, {63'd0, stall}, 64'd1);
        checkOutput({tag, "_hilo"}, HILO_out, expected);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int valid_seen;
        check_count = 0;
        error_count = 0;
        rset    = 1'b1;
        start   = 1'b0;
        sign    = 1'b0;
        cancel  = 1'b0;
        value_A = '0;
        value_B = '0;

        @(negedge clk);
        checkOutput("reset_hilo", HILO_out, 64'd0);
        checkOutput("reset_stall", {63'd0, stall}, 64'd1);
        checkOutput("reset_valid", {63'd0, result_valid}, 64'd0);
        @(posedge clk);
        #1;
        rset = 1'b0;
        @(posedge clk);
        #1;

        // First pair also exercises back-to-back acceptance right after DONE.
        applyStimulus("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        applyStimulus("udiv_btb", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF});
        applyStimulus("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        applyStimulus("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
        applyStimulus("sdiv_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
        applyStimulus("udiv_zero", 1'b0, 32'd5, 32'd0, {32'h00000005, 32'hFFFFFFFF});
        applyStimulus("sdiv_zero", 1'b1, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF});
        applyStimulus("sdiv_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2});

        // Cancel at cycle 10 of a divide; previous result must survive.
        start   = 1'b1;
        sign    = 1'b0;
        value_A = 32'd1000;
        value_B = 32'd3;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        checkOutput("cancel_stall", {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        start  = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) valid_seen++;
        end
        checkOutput("cancel_no_valid", 64'(valid_seen), 64'd0);
        checkOutput("cancel_idle_stall", {63'd0, stall}, 64'd1);
        checkOutput("cancel_hilo_kept", HILO_out, {32'hFFFFFFFE, 32'hFFFFFFF2});

        // Asynchronous reset between edges, 20 cycles into a divide.
        @(posedge clk);
        #1;
        start   = 1'b1;
        value_A = 32'd77;
        value_B = 32'd5;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #2;
        rset  = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("async_rst_hilo", HILO_out, 64'd0);
        checkOutput("async_rst_stall", {63'd0, stall}, 64'd1);
        checkOutput("async_rst_valid", {63'd0, result_valid}, 64'd0);
        #1;
        rset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("post_rst_div", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
